vis_centroid_overlay: RTL and testbench
=======================================

Name: vis_centroid_overlay

Overview:
Streaming vision block that accumulates the image moments (area, sum x, sum y) of a binarized frame and computes its centroid during vertical blanking with a sequential divider. It overlays a configurable marker at the previous frame's centroid on the live video. It sits after the binarization stage, ahead of the HDMI/VGA output, on the same de/hsync/vsync/24-bit pixel bus. It supersedes the fixed, externally-supplied crosshair overlay.

Parameters:
IMG_W, 64, active pixels per line (1..2047)
IMG_H, 64, active lines per frame (1..2047)
MARK_COLOR, 24'hFF0000, RGB value drawn for marker pixels
THICK, 0, marker half-thickness in pixels (line width = 2*THICK+1)
ARM, 8, arm length in pixels for short-cross mode
MIN_AREA, 1, minimum foreground pixel count for a valid centroid

Ports:
clk  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
de  in  1  data enable, active pixel
hsync  in  1  horizontal sync
vsync  in  1  vertical sync; high = blanking, rising edge = end of frame
pixel_in  in  24  RGB pixel; foreground when pixel_in[7] = 1
mode  in  2  00 pass, 01 full crosshair, 10 short cross (ARM), 11 square dot
de_out  out  1  de delayed 1 clk
hsync_out  out  1  hsync delayed 1 clk
vsync_out  out  1  vsync delayed 1 clk
pixel_out  out  24  overlaid pixel, 1 clk latency
x_c  out  11  centroid column of last valid frame
y_c  out  11  centroid row of last valid frame
valid  out  1  1 = x_c/y_c belong to the most recent frame

Behaviour:
- Reset (rst_n = 0 at a clk edge): all outputs 0, position counters 0, accumulators 0, FSM IDLE, latched mode 00. Reset wins over every other event, including mid-division.
- Position: x_pos/y_pos cleared while vsync = 1. On de = 1, x_pos increments; at x_pos = IMG_W-1 it wraps to 0 and y_pos increments.
- Accumulate: on de & pixel_in[7], m00 += 1, m10 += x_pos, m01 += y_pos. Widths come from package functions: AW0 = clog2(IMG_W*IMG_H+1), AW1 = AW0+11. No overflow is possible by construction.
- Rising edge of vsync (registered edge detect):
  - Snapshot m00/m10/m01 into the divider operands, clear the accumulators, and latch mode into mode_q.
  - The snapshot includes the final pixel if de is high on the cycle before the edge.
- FSM IDLE -> CHECK (1 clk):
  - If snapshot m00 < MIN_AREA or m00 = 0: set valid <= 0, hold x_c/y_c, return to IDLE.
  - Otherwise go to DIV.
- FSM DIV: two restoring dividers in parallel, one quotient bit per clk, 11 iterations, quotient = floor(m10/m00), floor(m01/m00). Then DONE: x_c/y_c <= quotients, valid <= 1, return to IDLE.
- Latency from vsync rise to result: at most 14 clk. Vertical blanking must be at least 16 clk.
- A new vsync rising edge while in CHECK or DIV aborts the current division and restarts with the new snapshot.
- Overlay: registered stage, so de_out/hsync_out/vsync_out/pixel_out are inputs delayed by exactly 1 clk. Let dx = |x_pos - x_c| and dy = |y_pos - y_c|. Pixel_out = MARK_COLOR when valid = 1, de = 1 and:
  - mode 01: dx <= THICK or dy <= THICK
  - mode 10: (dx <= THICK and dy <= ARM) or (dy <= THICK and dx <= ARM)
  - mode 11: dx <= THICK and dy <= THICK
  - Otherwise pixel_out = pixel_in (mode 00 is always pass-through).
- Mode changes take effect only at the next vsync rising edge, so there is no mid-frame tearing.
- The marker uses the centroid of frame N while frame N+1 streams in.

Decomposition:
- Package vis_pkg holds: clog2 function; accumulator width functions; mode encodings MODE_PASS, MODE_CROSS, MODE_SHORT, MODE_DOT; FSM state encodings IDLE/CHECK/DIV/DONE.
- Sub-module seq_divider (parametrised dividend width, divisor width, 11-bit quotient) has a start/busy/done handshake:
  - start is accepted in any state and restarts the division.
  - done pulses for 1 clk.
  - Two instances are used, for x and y.

Test Plan:
- rst_n low 3 clk mid-frame, in DIV -> every output 0, valid 0; the next frame computes normally.
- 64x64 frame with a foreground square at x 10..13, y 20..23 (m00 = 16, m10 = 184, m01 = 344) -> within 14 clk of vsync rise: x_c = 11, y_c = 21, valid = 1.
- All-background frame after a valid frame -> valid = 0, x_c/y_c hold 11/21; the next frame shows no marker.
- mode = 01, THICK = 0, frame after the square frame -> pixel_out = FF0000 exactly on column 11 and row 21, all other pixels equal pixel_in delayed 1 clk; de/hsync/vsync out delayed 1 clk.
- Full-foreground frame -> m00 = 4096, x_c = 31, y_c = 31, no overflow. Single pixel at (63,63) -> x_c = 63, y_c = 63.
- mode switched 01 -> 10 mid-frame, ARM = 2 -> current frame remains a full crosshair; the next frame shows a 5x5 cross centred on the centroid.

Source files
------------

// File: rtl/vis_centroid_overlay_pkg.sv
// Shared types and width helpers for the centroid overlay block and its divider.
package vis_pkg;

  localparam int QW = 11;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'b00,
    MODE_CROSS = 2'b01,
    MODE_SHORT = 2'b10,
    MODE_DOT   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    DIV   = 2'b10,
    DONE  = 2'b11
  } state_e;

  function automatic int clog2(input longint v);
    int r;
    r = 0;
    while ((longint'(1) << r) < v) r = r + 1;
    return r;
  endfunction

  // Area counter must hold IMG_W*IMG_H; moment sums add an 11-bit coordinate on top.
  function automatic int acc_w0(input int w, input int h);
    return clog2(longint'(w) * longint'(h) + 1);
  endfunction

  function automatic int acc_w1(input int w, input int h);
    return acc_w0(w, h) + QW;
  endfunction

  function automatic logic [QW-1:0] abs_diff(input logic [QW-1:0] a, input logic [QW-1:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

endpackage

// File: rtl/vis_centroid_overlay_seq_divider.sv
// Restoring divider producing an 11-bit quotient, one bit per clock, MSB first.
module seq_divider
  import vis_pkg::*;
#(
  parameter int DW = 24,
  parameter int VW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  localparam int RW = (DW > VW + QW) ? DW : VW + QW;

  logic [RW-1:0] rem_q;
  logic [RW-1:0] dsh_q;
  logic [3:0]    cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q    <= '0;
      dsh_q    <= '0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= RW'(dividend);
        dsh_q    <= RW'(divisor) << (QW - 1);
        cnt_q    <= 4'(QW - 1);
        quotient <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        // Quotient is known to fit 11 bits, so the divisor starts pre-shifted by 10.
        if (rem_q >= dsh_q) begin
          rem_q    <= rem_q - dsh_q;
          quotient <= {quotient[QW-2:0], 1'b1};
        end else begin
          quotient <= {quotient[QW-2:0], 1'b0};
        end
        dsh_q <= dsh_q >> 1;
        if (cnt_q == 4'd0) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vis_centroid_overlay.sv
// Accumulates foreground moments per frame, divides for the centroid during vblank,
// and overlays a marker at the previous frame's centroid on the live pixel stream.
module vis_centroid_overlay
  import vis_pkg::*;
#(
  parameter int          IMG_W      = 64,
  parameter int          IMG_H      = 64,
  parameter logic [23:0] MARK_COLOR = 24'hFF0000,
  parameter int          THICK      = 0,
  parameter int          ARM        = 8,
  parameter int          MIN_AREA   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [23:0] pixel_in,
  input  logic [1:0]  mode,
  output logic        de_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [23:0] pixel_out,
  output logic [10:0] x_c,
  output logic [10:0] y_c,
  output logic        valid
);

  localparam int AW0 = acc_w0(IMG_W, IMG_H);
  localparam int AW1 = acc_w1(IMG_W, IMG_H);
  localparam logic [QW-1:0]  LAST_X  = QW'(IMG_W - 1);
  localparam logic [QW-1:0]  THICK_L = QW'(THICK);
  localparam logic [QW-1:0]  ARM_L   = QW'(ARM);
  localparam logic [AW0-1:0] MIN_L   = AW0'(MIN_AREA);

  logic           vsync_d, vs_rise;
  logic [QW-1:0]  x_pos, y_pos;
  logic [AW0-1:0] m00, m00_s;
  logic [AW1-1:0] m10, m01, m10_s, m01_s;
  mode_e          mode_q;
  state_e         state, state_n;
  logic           div_start, res_load, res_clear;
  logic           x_busy, y_busy, x_done, y_done;
  logic [QW-1:0]  x_quo, y_quo, dx, dy;
  logic           mark;

  assign vs_rise = vsync & ~vsync_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (vsync) begin
      x_pos <= '0;
      y_pos <= '0;
    end else if (de) begin
      if (x_pos == LAST_X) begin
        x_pos <= '0;
        y_pos <= y_pos + 1'b1;
      end else begin
        x_pos <= x_pos + 1'b1;
      end
    end
  end

  // The last active pixel lands in m00 one edge before the rise, so the snapshot includes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      mode_q  <= MODE_PASS;
      m00     <= '0;
      m10     <= '0;
      m01     <= '0;
      m00_s   <= '0;
      m10_s   <= '0;
      m01_s   <= '0;
    end else begin
      vsync_d <= vsync;
      if (vs_rise) begin
        m00_s  <= m00;
        m10_s  <= m10;
        m01_s  <= m01;
        m00    <= '0;
        m10    <= '0;
        m01    <= '0;
        mode_q <= mode_e'(mode);
      end else if (de && pixel_in[7]) begin
        m00 <= m00 + 1'b1;
        m10 <= m10 + AW1'(x_pos);
        m01 <= m01 + AW1'(y_pos);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_n   = state;
    div_start = 1'b0;
    res_load  = 1'b0;
    res_clear = 1'b0;
    unique case (state)
      IDLE: ;
      CHECK: begin
        if (m00_s == '0 || m00_s < MIN_L) begin
          res_clear = 1'b1;
          state_n   = IDLE;
        end else begin
          div_start = 1'b1;
          state_n   = DIV;
        end
      end
      DIV: begin
        if (x_done && y_done) begin
          res_load = 1'b1;
          state_n  = DONE;
        end else if (!x_busy && !y_busy) begin
          state_n = IDLE;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    // A fresh frame end abandons whatever is in flight and restarts on the new snapshot.
    if (vs_rise) begin
      state_n   = CHECK;
      div_start = 1'b0;
      res_load  = 1'b0;
      res_clear = 1'b0;
    end
  end

  seq_divider #(.DW(AW1), .VW(AW0)) u_div_x (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (m10_s),
    .divisor  (m00_s),
    .busy     (x_busy),
    .done     (x_done),
    .quotient (x_quo)
  );

  seq_divider #(.DW(AW1), .VW(AW0)) u_div_y (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (m01_s),
    .divisor  (m00_s),
    .busy     (y_busy),
    .done     (y_done),
    .quotient (y_quo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_c   <= '0;
      y_c   <= '0;
      valid <= 1'b0;
    end else if (res_clear) begin
      valid <= 1'b0;
    end else if (res_load) begin
      x_c   <= x_quo;
      y_c   <= y_quo;
      valid <= 1'b1;
    end
  end

  assign dx = abs_diff(x_pos, x_c);
  assign dy = abs_diff(y_pos, y_c);

  always_comb begin
    mark = 1'b0;
    if (valid && de) begin
      unique case (mode_q)
        MODE_CROSS: mark = (dx <= THICK_L) || (dy <= THICK_L);
        MODE_SHORT: mark = ((dx <= THICK_L) && (dy <= ARM_L)) ||
                           ((dy <= THICK_L) && (dx <= ARM_L));
        MODE_DOT:   mark = (dx <= THICK_L) && (dy <= THICK_L);
        default:    mark = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de_out    <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      pixel_out <= '0;
    end else begin
      de_out    <= de;
      hsync_out <= hsync;
      vsync_out <= vsync;
      pixel_out <= mark ? MARK_COLOR : pixel_in;
    end
  end

endmodule

// File: tb/tb_vis_centroid_overlay.sv
// Scoreboard bench: a frame-level model predicts delayed/overlaid pixels and per-frame centroids.
module tb_vis_centroid_overlay;

  localparam int          W        = 64;
  localparam int          H        = 64;
  localparam int          THICK    = 0;
  localparam int          ARM      = 2;
  localparam int          MIN_AREA = 1;
  localparam logic [23:0] RED      = 24'hFF0000;

  localparam int K_SQUARE = 0;
  localparam int K_EMPTY  = 1;
  localparam int K_FULL   = 2;
  localparam int K_SINGLE = 3;
  localparam int K_RAND   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        de = 1'b0, hsync = 1'b0, vsync = 1'b1;
  logic [23:0] pixel_in = '0;
  logic [1:0]  mode = 2'b00;
  logic        de_out, hsync_out, vsync_out, valid;
  logic [23:0] pixel_out;
  logic [10:0] x_c, y_c;

  vis_centroid_overlay #(
    .IMG_W(W), .IMG_H(H), .MARK_COLOR(RED), .THICK(THICK), .ARM(ARM), .MIN_AREA(MIN_AREA)
  ) dut (
    .clk(clk), .rst_n(rst_n), .de(de), .hsync(hsync), .vsync(vsync),
    .pixel_in(pixel_in), .mode(mode),
    .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out), .pixel_out(pixel_out),
    .x_c(x_c), .y_c(y_c), .valid(valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [26:0] bus;
  } pix_t;

  pix_t        pix_q[$];
  logic [22:0] res_q[$];

  int errors = 0;
  int checks = 0;

  bit   hold_rst = 1'b1;
  bit   m_valid  = 1'b0;
  int   m_xc = 0, m_yc = 0;
  logic [1:0] m_mode = 2'b00;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit marker(input int x, input int y);
    int dx, dy;
    if (!m_valid) return 1'b0;
    dx = (x > m_xc) ? x - m_xc : m_xc - x;
    dy = (y > m_yc) ? y - m_yc : m_yc - y;
    case (m_mode)
      2'b01:   return (dx <= THICK) || (dy <= THICK);
      2'b10:   return ((dx <= THICK) && (dy <= ARM)) || ((dy <= THICK) && (dx <= ARM));
      2'b11:   return (dx <= THICK) && (dy <= THICK);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit is_fg(input int kind, input int x, input int y, input int dens);
    case (kind)
      K_SQUARE: return (x >= 10 && x <= 13 && y >= 20 && y <= 23);
      K_EMPTY:  return 1'b0;
      K_FULL:   return 1'b1;
      K_SINGLE: return (x == 63 && y == 63);
      default:  return ($urandom_range(0, 99) < dens);
    endcase
  endfunction

  // One clock of stimulus; expected output is due on the following edge.
  task automatic step(input logic d, input logic h, input logic v, input logic [23:0] p, input bit mk);
    pix_t e;
    @(posedge clk);
    #1;
    rst_n    = !hold_rst;
    de       = d;
    hsync    = h;
    vsync    = v;
    pixel_in = p;
    e.due = cyc + 1;
    e.bus = rst_n ? {d, h, v, (mk ? RED : p)} : 27'd0;
    pix_q.push_back(e);
  endtask

  task automatic blank(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0);
  endtask

  task automatic run_frame(input int kind, input int dens, input logic [1:0] md,
                           input int sw_line, input logic [1:0] md2, input bit do_reset);
    int cnt, sx, sy;
    logic [23:0] p;
    bit fg;
    cnt = 0; sx = 0; sy = 0;
    mode = md;
    for (int y = 0; y < H; y++) begin
      if (y == sw_line) mode = md2;
      for (int x = 0; x < W; x++) begin
        if ($urandom_range(0, 15) == 0) step(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
        fg = is_fg(kind, x, y, dens);
        p = 24'($urandom);
        p[7] = fg;
        step(1'b1, 1'b0, 1'b0, p, marker(x, y));
        if (fg) begin
          cnt++;
          sx += x;
          sy += y;
        end
      end
      step(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
      step(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0);
      step(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0);
      step(1'b0, 1'b0, 1'b0, 24'($urandom), 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 24'($urandom), 1'b0);
    m_mode = mode;
    if (cnt >= MIN_AREA && cnt > 0) begin
      m_valid = 1'b1;
      m_xc = sx / cnt;
      m_yc = sy / cnt;
    end else begin
      m_valid = 1'b0;
    end
    if (!do_reset) begin
      res_q.push_back({m_valid, 11'(m_xc), 11'(m_yc)});
      blank(19);
    end else begin
      blank(5);
      hold_rst = 1'b1;
      blank(3);
      hold_rst = 1'b0;
      blank(1);
      check("reset_mid_div", 64'({valid, x_c, y_c, de_out, hsync_out, vsync_out, pixel_out}), 64'd0);
      m_valid = 1'b0; m_xc = 0; m_yc = 0; m_mode = 2'b00;
      blank(13);
    end
  endtask

  // Centroid monitor: result must be present 14 clocks after vsync rises.
  int n_since = -1;
  bit vs_prev = 1'b0;
  always @(negedge clk) begin : res_mon
    logic [22:0] exp_r;
    if (vsync && !vs_prev) n_since = 0;
    else if (n_since >= 0) n_since = n_since + 1;
    vs_prev = vsync;
    if (n_since == 14) begin
      n_since = -1;
      if (res_q.size() > 0) begin
        exp_r = res_q.pop_front();
        check("centroid{valid,x_c,y_c}", 64'({valid, x_c, y_c}), 64'(exp_r));
      end
    end
  end

  always @(negedge clk) begin : pix_mon
    pix_t e;
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      e = pix_q.pop_front();
      check($sformatf("pix@%0d", e.due),
            64'({de_out, hsync_out, vsync_out, pixel_out}), 64'(e.bus));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    hold_rst = 1'b1;
    blank(3);
    hold_rst = 1'b0;
    blank(1);
    check("reset_state", 64'({valid, x_c, y_c, de_out, hsync_out, vsync_out, pixel_out}), 64'd0);
    blank(4);

    run_frame(K_SQUARE, 0,  2'b01, -1, 2'b01, 1'b0);
    run_frame(K_EMPTY,  0,  2'b01, -1, 2'b01, 1'b0);
    run_frame(K_RAND,   30, 2'b01, -1, 2'b01, 1'b0);
    run_frame(K_FULL,   0,  2'b01, 32, 2'b10, 1'b0);
    run_frame(K_SINGLE, 0,  2'b10, -1, 2'b10, 1'b0);
    run_frame(K_RAND,   20, 2'b11, -1, 2'b11, 1'b0);
    run_frame(K_SQUARE, 0,  2'b11, -1, 2'b11, 1'b1);
    run_frame(K_RAND,   40, 2'b01, -1, 2'b01, 1'b0);
    run_frame(K_RAND,   10, 2'b01, -1, 2'b01, 1'b0);

    blank(3);
    repeat (2) @(negedge clk);
    check("res_q_drained", 64'(res_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
